// File: rtl/m_lcd_spi_pkg.sv
// Shared types and FIFO entry layout for the LCD SPI transmitter.
package m_lcd_spi_pkg;

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, GAP} state_t;

    localparam int ENTRY_W  = 18;
    localparam int DC_BIT   = 17;
    localparam int WIDE_BIT = 16;
    localparam int DATA_MSB = 15;
    localparam int DATA_LSB = 0;

    // 8-bit words are left-justified so the shifter always sends from bit 15.
    function automatic logic [15:0] left_justify(input logic wide, input logic [15:0] d);
        return wide ? d : {d[7:0], 8'h00};
    endfunction

endpackage

// File: rtl/m_lcd_spi_tx_fifo.sv
// Synchronous FIFO with occupancy count; head is read straight from storage.
module m_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16
) (
    input  logic                     w_clk,
    input  logic                     w_rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LW-1:0]    cnt;
    logic             push_ok, pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge w_clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == LW'(DEPTH));
    assign empty = (cnt == '0);
    assign level = cnt;

endmodule

// File: rtl/m_lcd_spi_tx.sv
// FIFO-fed SPI transmitter for ST7789-class panels: programmable SCL divider,
// CPOL, 8/16-bit words, CS held low across bursts, sticky overflow flag.
module m_lcd_spi_tx
    import m_lcd_spi_pkg::*;
#(
    parameter int CLK_DIV    = 1,
    parameter bit CPOL       = 1'b1,
    parameter int FIFO_DEPTH = 16,
    parameter int GAP_CYC    = 0
) (
    input  logic                          w_clk,
    input  logic                          w_rst,
    input  logic                          w_valid,
    output logic                          w_ready,
    input  logic                          w_dc,
    input  logic                          w_wide,
    input  logic [15:0]                   w_data,
    input  logic                          w_ovf_clr,
    output logic                          SDA,
    output logic                          SCL,
    output logic                          DC,
    output logic                          CSN,
    output logic                          w_busy,
    output logic [$clog2(FIFO_DEPTH):0]   w_level,
    output logic                          w_ovf
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    logic [ENTRY_W-1:0] push_e, head;
    logic               fifo_full, fifo_empty, pop;
    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic               half;
    logic [4:0]         bit_cnt;
    logic [15:0]        sh;
    logic               dc_q, ovf_q;
    logic [7:0]         gap_cnt;
    logic               last_bit, eow;

    assign push_e = {w_dc, w_wide, w_data};

    m_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .w_clk (w_clk),
        .w_rst (w_rst),
        .push  (w_valid && w_ready),
        .din   (push_e),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (w_level)
    );

    assign last_bit = (state == SHIFT) && half && (div_cnt == DIV_LAST) && (bit_cnt == 5'd1);
    assign eow      = (GAP_CYC == 0) ? last_bit : ((state == GAP) && (gap_cnt == GAP_LAST));

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!fifo_empty) state_nxt = LEAD;
            LEAD:  state_nxt = SHIFT;
            SHIFT: if (last_bit)
                       state_nxt = (GAP_CYC > 0) ? GAP : (fifo_empty ? IDLE : SHIFT);
            GAP:   if (eow) state_nxt = fifo_empty ? IDLE : SHIFT;
            default: state_nxt = IDLE;
        endcase
    end

    // SCL leaves idle only during the first half of each bit.
    always_comb begin
        pop = 1'b0;
        SCL = CPOL;
        CSN = 1'b1;
        pop = ((state == IDLE) || eow) && !fifo_empty;
        if ((state == SHIFT) && !half) SCL = ~CPOL;
        if (state != IDLE) CSN = 1'b0;
    end

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            sh      <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            half    <= 1'b0;
            dc_q    <= 1'b0;
            gap_cnt <= '0;
        end else if (pop) begin
            sh      <= left_justify(head[WIDE_BIT], head[DATA_MSB:DATA_LSB]);
            bit_cnt <= head[WIDE_BIT] ? 5'd16 : 5'd8;
            dc_q    <= head[DC_BIT];
            div_cnt <= '0;
            half    <= 1'b0;
        end else if (state == SHIFT) begin
            gap_cnt <= '0;
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                half    <= ~half;
                if (half && (bit_cnt != 5'd1)) begin
                    sh      <= {sh[14:0], 1'b0};
                    bit_cnt <= bit_cnt - 5'd1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end else if (state == GAP) begin
            gap_cnt <= gap_cnt + 8'd1;
        end
    end

    // A refused push in the same cycle as a clear keeps the flag set.
    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst)                    ovf_q <= 1'b0;
        else if (w_valid && !w_ready) ovf_q <= 1'b1;
        else if (w_ovf_clr)           ovf_q <= 1'b0;
    end

    assign w_ready = !fifo_full;
    assign w_busy  = (state != IDLE) || !fifo_empty;
    assign w_ovf   = ovf_q;
    assign SDA     = sh[15];
    assign DC      = dc_q;

endmodule

// File: tb/tb_m_lcd_spi_tx.sv
// Directed bench: default-parameter instance plus a CLK_DIV=3/CPOL=0/GAP=4 instance.
module tb_m_lcd_spi_tx;

    logic w_clk = 1'b0;
    logic w_rst = 1'b0;
    always #5 w_clk = ~w_clk;

    logic valid = 0, dc = 0, wide = 0, ovf_clr = 0;
    logic [15:0] data = '0;
    logic sda, scl, dco, csn, ready, busy, ovf;
    logic [4:0] level;

    logic v5 = 0, dc5 = 0, wide5 = 0, clr5 = 0;
    logic [15:0] data5 = '0;
    logic sda5, scl5, dco5, csn5, ready5, busy5, ovf5;
    logic [4:0] level5;

    m_lcd_spi_tx dut (
        .w_clk(w_clk), .w_rst(w_rst), .w_valid(valid), .w_ready(ready),
        .w_dc(dc), .w_wide(wide), .w_data(data), .w_ovf_clr(ovf_clr),
        .SDA(sda), .SCL(scl), .DC(dco), .CSN(csn),
        .w_busy(busy), .w_level(level), .w_ovf(ovf)
    );

    m_lcd_spi_tx #(.CLK_DIV(3), .CPOL(1'b0), .FIFO_DEPTH(16), .GAP_CYC(4)) dut5 (
        .w_clk(w_clk), .w_rst(w_rst), .w_valid(v5), .w_ready(ready5),
        .w_dc(dc5), .w_wide(wide5), .w_data(data5), .w_ovf_clr(clr5),
        .SDA(sda5), .SCL(scl5), .DC(dco5), .CSN(csn5),
        .w_busy(busy5), .w_level(level5), .w_ovf(ovf5)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge w_clk) cyc <= cyc + 1;

    // Sampling-edge capture: rising SCL for the default instance, falling for dut5.
    logic cap_sda [512];
    logic cap_dc  [512];
    int   cap_cyc [512];
    int   cap_n = 0;
    int   rise_cyc [64];
    int   rise_n = 0;
    logic prev_scl = 1'b1, prev_csn = 1'b1;
    always @(negedge w_clk) begin
        if (!prev_scl && scl && !csn && cap_n < 512) begin
            cap_sda[cap_n] <= sda;
            cap_dc[cap_n]  <= dco;
            cap_cyc[cap_n] <= cyc;
            cap_n <= cap_n + 1;
        end
        if (!prev_csn && csn && rise_n < 64) begin
            rise_cyc[rise_n] <= cyc;
            rise_n <= rise_n + 1;
        end
        prev_scl <= scl;
        prev_csn <= csn;
    end

    logic s5_sda [64];
    int   s5_cyc [64];
    int   s5_n = 0;
    int   r5_n = 0;
    logic prev_scl5 = 1'b0, prev_csn5 = 1'b1;
    always @(negedge w_clk) begin
        if (prev_scl5 && !scl5 && !csn5 && s5_n < 64) begin
            s5_sda[s5_n] <= sda5;
            s5_cyc[s5_n] <= cyc;
            s5_n <= s5_n + 1;
        end
        if (!prev_csn5 && csn5) r5_n <= r5_n + 1;
        prev_scl5 <= scl5;
        prev_csn5 <= csn5;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic push(input logic d, input logic w, input logic [15:0] v);
        valid = 1; dc = d; wide = w; data = v;
        tick();
        valid = 0;
    endtask

    task automatic wait_idle(input bit sel, input int budget, input string tag);
        int n = 0;
        while ((sel ? busy5 : busy) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, sel ? busy5 : busy}, 32'd0);
    endtask

    function automatic logic [31:0] bits_at(input int base, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) r = {r[30:0], cap_sda[base + i]};
        return r;
    endfunction

    function automatic logic [31:0] bits5_at(input int base, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++) r = {r[30:0], s5_sda[base + i]};
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int base, rb, t, acc, b5, rb5;
        logic dcall;
        logic [7:0] exp_b;

        // 1: asynchronous reset before any clock edge
        #2 w_rst = 1;
        #1;
        chk("rst_scl",   {31'd0, scl},   32'd1);
        chk("rst_csn",   {31'd0, csn},   32'd1);
        chk("rst_dc",    {31'd0, dco},   32'd0);
        chk("rst_sda",   {31'd0, sda},   32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_level", {27'd0, level}, 32'd0);
        chk("rst_ovf",   {31'd0, ovf},   32'd0);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_scl5",  {31'd0, scl5},  32'd0);
        @(posedge w_clk);
        @(posedge w_clk);
        #1 w_rst = 0;
        tick(); tick();

        // 2: single 8-bit command 0x2A
        base = cap_n; rb = rise_n; t = cyc;
        push(1'b0, 1'b0, 16'h002A);
        tick();
        chk("t2_csn_low", {31'd0, csn}, 32'd0);
        chk("t2_dc",      {31'd0, dco}, 32'd0);
        repeat (25) tick();
        chk("t2_nbits",   cap_n - base, 32'd8);
        chk("t2_bits",    bits_at(base, 8), 32'h2A);
        chk("t2_edge0",   cap_cyc[base], t + 4);
        chk("t2_edge7",   cap_cyc[base + 7], t + 18);
        chk("t2_nrise",   rise_n - rb, 32'd1);
        chk("t2_csn_up",  rise_cyc[rb], t + 19);

        // 3: 16-bit then 8-bit data word, back to back
        base = cap_n; rb = rise_n; t = cyc;
        push(1'b1, 1'b1, 16'hF800);
        push(1'b1, 1'b0, 16'h0055);
        wait_idle(1'b0, 100, "t3_idle");
        tick();
        chk("t3_nbits", cap_n - base, 32'd24);
        chk("t3_bits",  bits_at(base, 24), 32'h00F80055);
        chk("t3_span",  cap_cyc[base + 23] - cap_cyc[base], 32'd46);
        chk("t3_nrise", rise_n - rb, 32'd1);
        chk("t3_up",    rise_cyc[rb], t + 51);
        dcall = 1'b1;
        for (int i = 0; i < 24; i++) dcall = dcall & cap_dc[base + i];
        chk("t3_dc", {31'd0, dcall}, 32'd1);

        // 4: 20 continuous pushes into a 16-deep FIFO
        base = cap_n; acc = 0;
        for (int i = 0; i < 20; i++) begin
            valid = 1; dc = 0; wide = 0; data = 16'h0040 + 16'(i);
            if (i == 17) begin
                chk("t4_level16",  {27'd0, level}, 32'd16);
                chk("t4_ready_lo", {31'd0, ready}, 32'd0);
                chk("t4_ovf_pre",  {31'd0, ovf},   32'd0);
            end
            if (i == 18) begin
                chk("t4_ovf_set", {31'd0, ovf}, 32'd1);
                ovf_clr = 1;
            end
            if (i == 19) begin
                chk("t4_ovf_wins", {31'd0, ovf},   32'd1);
                chk("t4_ready_hi", {31'd0, ready}, 32'd1);
                ovf_clr = 0;
            end
            if (ready) acc++;
            tick();
        end
        valid = 0;
        chk("t4_accepted", acc, 32'd18);
        wait_idle(1'b0, 400, "t4_idle");
        tick();
        chk("t4_nbits", cap_n - base, 32'd144);
        for (int j = 0; j < 18; j++) begin
            exp_b = (j < 17) ? 8'(8'h40 + j) : 8'h53;
            chk($sformatf("t4_word%0d", j), bits_at(base + 8 * j, 8), {24'd0, exp_b});
        end
        chk("t4_ovf_hold", {31'd0, ovf}, 32'd1);
        ovf_clr = 1;
        tick();
        ovf_clr = 0;
        chk("t4_ovf_clr", {31'd0, ovf}, 32'd0);

        // 5: CLK_DIV=3, CPOL=0, GAP_CYC=4 instance
        b5 = s5_n; rb5 = r5_n; t = cyc;
        v5 = 1; dc5 = 1; wide5 = 0; data5 = 16'h00A5;
        tick();
        data5 = 16'h003C;
        tick();
        v5 = 0;
        chk("t5_csn_low",  {31'd0, csn5}, 32'd0);
        chk("t5_scl_lead", {31'd0, scl5}, 32'd0);
        tick();
        chk("t5_scl_hi0", {31'd0, scl5}, 32'd1);
        tick(); tick();
        chk("t5_scl_hi2", {31'd0, scl5}, 32'd1);
        tick();
        chk("t5_scl_lo",  {31'd0, scl5}, 32'd0);
        wait_idle(1'b1, 200, "t5_idle");
        tick();
        chk("t5_nbits",  s5_n - b5, 32'd16);
        chk("t5_bits",   bits5_at(b5, 16), 32'hA53C);
        chk("t5_edge0",  s5_cyc[b5], t + 6);
        chk("t5_period", s5_cyc[b5 + 1] - s5_cyc[b5], 32'd6);
        chk("t5_gap",    s5_cyc[b5 + 8] - s5_cyc[b5 + 7], 32'd10);
        chk("t5_nrise",  r5_n - rb5, 32'd1);
        chk("t5_dc",     {31'd0, dco5}, 32'd1);
        chk("t5_idle_scl", {31'd0, scl5}, 32'd0);
        chk("t5_ovf",    {31'd0, ovf5}, 32'd0);
        chk("t5_level",  {27'd0, level5}, 32'd0);
        chk("t5_ready",  {31'd0, ready5}, 32'd1);

        // 6: reset during bit 9 of a 16-bit word with 3 words queued
        base = cap_n; t = cyc;
        for (int i = 0; i < 4; i++) push(1'b1, 1'b1, 16'h8001 + 16'(i));
        while (cyc < t + 19) tick();
        chk("t6_nbits_pre", cap_n - base, 32'd8);
        chk("t6_level_pre", {27'd0, level}, 32'd3);
        #2 w_rst = 1;
        #1;
        chk("t6_csn",   {31'd0, csn},   32'd1);
        chk("t6_scl",   {31'd0, scl},   32'd1);
        chk("t6_level", {27'd0, level}, 32'd0);
        chk("t6_busy",  {31'd0, busy},  32'd0);
        chk("t6_ready", {31'd0, ready}, 32'd1);
        chk("t6_sda",   {31'd0, sda},   32'd0);
        chk("t6_dc",    {31'd0, dco},   32'd0);
        @(posedge w_clk);
        #1 w_rst = 0;
        base = cap_n;
        repeat (40) tick();
        chk("t6_quiet",     cap_n - base, 32'd0);
        chk("t6_csn_after", {31'd0, csn},  32'd1);
        chk("t6_busy_after",{31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
